// File: rtl/mult_arbiter_3.sv
// Three-requester round-robin front end for a shared 3-stage multiplier.
// Grants are combinational, operands are registered at the accept edge,
// and a requester-ID tag pipeline routes each product back to its owner
// two edges later.
module mult_arbiter_3 #(
  parameter int A_width = 8,
  parameter int B_width = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [2:0]                   REQ,
  input  logic [3*A_width-1:0]         REQ_A,
  input  logic [3*B_width-1:0]         REQ_B,
  input  logic [2:0]                   REQ_TC,
  input  logic                         DRAIN,
  output logic [2:0]                   GNT,
  output logic [A_width-1:0]           MUL_A,
  output logic [B_width-1:0]           MUL_B,
  output logic                         MUL_TC,
  input  logic [A_width+B_width-1:0]   MUL_PRODUCT,
  output logic [2:0]                   RES_VALID,
  output logic [A_width+B_width-1:0]   RES_DATA,
  output logic [1:0]                   INFLIGHT,
  output logic                         IDLE
);

  // Requester that is searched first on the next arbitration.
  logic [1:0]         prio_q;
  logic               gnt_any;
  logic [1:0]         gnt_id;
  logic               accept;
  logic [A_width-1:0] sel_a;
  logic [B_width-1:0] sel_b;
  logic               sel_tc;

  // Tag pipeline: launch (_p0), stage1 (_p1), stage2 (_p2).
  logic               vld_p0, vld_p1, vld_p2;
  logic [1:0]         id_p0, id_p1, id_p2;

  // Modulo-3 increment of a requester index.
  function automatic logic [1:0] wrap_inc(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // Number of valid tags among the three pipeline stages (0..3).
  function automatic logic [1:0] count_vld(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

  // Round-robin search starting at prio_q, wrapping modulo 3.
  always_comb begin
    logic [1:0] cand;
    gnt_any = 1'b0;
    gnt_id  = 2'd0;
    cand    = prio_q;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_any && REQ[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // DRAIN masks the grant without disturbing the pointer.
  assign accept = gnt_any && !DRAIN;
  assign GNT    = accept ? (3'b001 << gnt_id) : 3'b000;

  // Select the granted requester's operand slices.
  always_comb begin
    sel_a  = REQ_A[int'(gnt_id)*A_width +: A_width];
    sel_b  = REQ_B[int'(gnt_id)*B_width +: B_width];
    sel_tc = REQ_TC[gnt_id];
  end

  // ---- launch stage: operand registers feeding the multiplier ----
  // Operands load on accept and hold otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MUL_A  <= '0;
      MUL_B  <= '0;
      MUL_TC <= 1'b0;
    end else if (accept) begin
      MUL_A  <= sel_a;
      MUL_B  <= sel_b;
      MUL_TC <= sel_tc;
    end
  end

  // Pointer moves past the granted requester only when a grant occurs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prio_q <= 2'd0;
    end else if (accept) begin
      prio_q <= wrap_inc(gnt_id);
    end
  end

  // ---- tag pipeline: launch -> stage1 -> stage2, never stalls ----
  // Reset discards every in-flight tag so no stale result is reported.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      id_p0  <= 2'd0;
      id_p1  <= 2'd0;
      id_p2  <= 2'd0;
    end else begin
      vld_p0 <= accept;
      id_p0  <= gnt_id;
      vld_p1 <= vld_p0;
      id_p1  <= id_p0;
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  // ---- result stage: stage2 tag steers the product back ----
  assign RES_VALID = vld_p2 ? (3'b001 << id_p2) : 3'b000;
  assign RES_DATA  = vld_p2 ? MUL_PRODUCT : '0;
  assign INFLIGHT  = count_vld(vld_p0, vld_p1, vld_p2);
  assign IDLE      = !(vld_p0 || vld_p1 || vld_p2);

endmodule

// File: tb/tb_mult_arbiter_3.sv
// Bench for mult_arbiter_3: directed scenarios followed by randomized
// traffic, all checked against a queue-based model of grants and results.
module tb_mult_arbiter_3;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int PW = AW + BW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [2:0]      req = '0;
  logic [3*AW-1:0] req_a = '0;
  logic [3*BW-1:0] req_b = '0;
  logic [2:0]      req_tc = '0;
  logic            drain = 1'b0;
  logic [2:0]      gnt;
  logic [AW-1:0]   mul_a;
  logic [BW-1:0]   mul_b;
  logic            mul_tc;
  logic [PW-1:0]   mul_product;
  logic [2:0]      res_valid;
  logic [PW-1:0]   res_data;
  logic [1:0]      inflight;
  logic            idle;

  always #5 clk = ~clk;

  mult_arbiter_3 #(.A_width(AW), .B_width(BW)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .REQ_A(req_a), .REQ_B(req_b),
    .REQ_TC(req_tc), .DRAIN(drain), .GNT(gnt), .MUL_A(mul_a), .MUL_B(mul_b),
    .MUL_TC(mul_tc), .MUL_PRODUCT(mul_product), .RES_VALID(res_valid),
    .RES_DATA(res_data), .INFLIGHT(inflight), .IDLE(idle)
  );

  function automatic logic [PW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                            input logic tc);
    logic signed [PW-1:0] sp;
    if (tc) begin
      sp = $signed(a) * $signed(b);
      return sp;
    end
    return PW'(a) * PW'(b);
  endfunction

  // Shared multiplier: two register stages behind the DUT's operand registers.
  logic [PW-1:0] m1, m2;
  always @(posedge clk) begin
    m1 <= ref_mul(mul_a, mul_b, mul_tc);
    m2 <= m1;
  end
  assign mul_product = m2;

  // Reference model: operations in flight with their age in edges.
  typedef struct {
    int            id;
    logic [PW-1:0] prod;
    int            age;
  } op_t;
  op_t           flight[$];
  int            prio;
  logic [AW-1:0] exp_a;
  logic [BW-1:0] exp_b;
  logic          exp_tc;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [2:0]    last_gnt;
  logic [2:0]    last_rv;
  logic [PW-1:0] last_rd;
  logic [2:0]    gseq[6];
  logic [2:0]    rvseq[9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_gnt();
    if (drain || req == 3'b000) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (prio + k) % 3;
      if (req[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic tc);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
    req_tc[i]         = tc;
  endtask

  task automatic set_rand_op(input int i);
    set_op(i, AW'($urandom), BW'($urandom), 1'($urandom));
  endtask

  // One clock: check combinational/result outputs before the edge,
  // advance the model at the edge, then check the operand registers.
  task automatic cycle();
    logic [2:0]    eg;
    logic [2:0]    erv;
    logic [PW-1:0] erd;
    int            gi;
    #3;
    eg  = model_gnt();
    erv = '0;
    erd = '0;
    foreach (flight[j]) begin
      if (flight[j].age == 2) begin
        erv = 3'(1 << flight[j].id);
        erd = flight[j].prod;
      end
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("res_valid", 32'(res_valid), 32'(erv));
    chk("res_data", 32'(res_data), 32'(erd));
    chk("inflight", 32'(inflight), 32'(flight.size()));
    chk("idle", 32'(idle), 32'(flight.size() == 0));
    last_gnt = gnt;
    last_rv  = res_valid;
    if (res_valid != 3'b000) last_rd = res_data;
    @(posedge clk);
    foreach (flight[j]) flight[j].age++;
    while (flight.size() > 0 && flight[0].age > 2) void'(flight.pop_front());
    if (eg != 3'b000) begin
      gi = 0;
      for (int k = 0; k < 3; k++) if (eg[k]) gi = k;
      exp_a  = req_a[gi*AW +: AW];
      exp_b  = req_b[gi*BW +: BW];
      exp_tc = req_tc[gi];
      flight.push_back('{id: gi, prod: ref_mul(exp_a, exp_b, exp_tc), age: 0});
      prio = (gi + 1) % 3;
    end
    #1;
    chk("mul_a", 32'(mul_a), 32'(exp_a));
    chk("mul_b", 32'(mul_b), 32'(exp_b));
    chk("mul_tc", 32'(mul_tc), 32'(exp_tc));
  endtask

  // Asynchronous reset pulse lasting one clock edge; outputs checked mid-reset.
  task automatic do_reset();
    req   = 3'b000;
    drain = 1'b0;
    rst_n = 1'b0;
    #1;
    flight.delete();
    prio   = 0;
    exp_a  = '0;
    exp_b  = '0;
    exp_tc = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_mul_tc", 32'(mul_tc), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    last_rd = '0;
    #2;
    do_reset();

    // Signed product: -3 * 5.
    req = 3'b001;
    set_op(0, 8'hFD, 8'h05, 1'b1);
    cycle();
    chk("t34_gnt", 32'(last_gnt), 32'h1);
    req = 3'b000;
    cycle(); cycle(); cycle();
    chk("t34_rv", 32'(last_rv), 32'h1);
    chk("t34_rd", 32'(last_rd), 32'hFFF1);
    cycle();

    // Unsigned product: 255 * 255.
    req = 3'b010;
    set_op(1, 8'hFF, 8'hFF, 1'b0);
    cycle();
    req = 3'b000;
    cycle(); cycle(); cycle();
    chk("t35_rv", 32'(last_rv), 32'h2);
    chk("t35_rd", 32'(last_rd), 32'hFE01);
    cycle();

    // All requesting for six cycles from a fresh pointer.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 3; i++) set_rand_op(i);
    for (int n = 0; n < 9; n++) begin
      if (n == 6) req = 3'b000;
      cycle();
      if (n < 6) gseq[n] = last_gnt;
      rvseq[n] = last_rv;
      if (n == 5) chk("t36_inflight", 32'(inflight), 32'd3);
      for (int i = 0; i < 3; i++) if (last_gnt[i]) set_rand_op(i);
    end
    for (int n = 0; n < 6; n++) begin
      logic [2:0] want;
      want = 3'(1 << (n % 3));
      chk("t36_gnt_seq", 32'(gseq[n]), 32'(want));
      if (n < 6 && n + 3 < 9) chk("t36_rv_seq", 32'(rvseq[n + 3]), 32'(want));
    end
    cycle(); cycle(); cycle();

    // Two accepts then DRAIN with everyone requesting.
    req = 3'b111;
    cycle();
    for (int i = 0; i < 3; i++) if (last_gnt[i]) set_rand_op(i);
    cycle();
    for (int i = 0; i < 3; i++) if (last_gnt[i]) set_rand_op(i);
    drain = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("t37_drain_gnt", 32'(last_gnt), 32'd0);
    end
    chk("t37_idle", 32'(idle), 32'd1);
    chk("t37_inflight", 32'(inflight), 32'd0);

    // DRAIN and REQ rising together: no grant, pointer untouched.
    req   = 3'b000;
    drain = 1'b0;
    cycle();
    req   = 3'b010;
    drain = 1'b1;
    cycle();
    chk("t30_gnt", 32'(last_gnt), 32'd0);
    drain = 1'b0;
    req   = 3'b111;
    cycle();
    req = 3'b000;
    cycle(); cycle(); cycle();

    // Reset one cycle after an accept discards the operation.
    req = 3'b100;
    set_rand_op(2);
    cycle();
    req = 3'b000;
    cycle();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("t38_no_result", 32'(last_rv), 32'd0);
    end
    req = 3'b111;
    cycle();
    chk("t38_first_gnt", 32'(last_gnt), 32'h1);
    req = 3'b000;
    cycle(); cycle(); cycle();

    // Wrap-around after a grant to requester 2.
    req = 3'b100;
    cycle();
    req = 3'b101;
    cycle();
    chk("t39_wrap_gnt0", 32'(last_gnt), 32'h1);
    req = 3'b100;
    cycle();
    chk("t39_wrap_gnt2", 32'(last_gnt), 32'h4);
    req = 3'b000;
    cycle(); cycle(); cycle();

    // Randomized traffic obeying hold-until-granted.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_rand_op(i);
          req[i] = 1'b1;
        end
      end
      drain = ($urandom_range(0, 7) == 0);
      cycle();
      req = req & ~last_gnt;
    end
    req   = 3'b000;
    drain = 1'b0;
    for (int n = 0; n < 4; n++) cycle();
    chk("final_idle", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
